// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and defaults for the shared-ALU arbiter.
package alu_pkg;

    localparam int unsigned OP_W        = 4;
    localparam int unsigned MUL_LAT_DEF = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_MUL = 4'd2;
    localparam logic [OP_W-1:0] ALU_AND = 4'd3;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only MUL uses the long latency; every other code completes in one cycle.
    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention, the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant_valid,
    output logic       grant_id
);

    assign grant_valid = en && (req != 2'b00);

    always_comb begin
        grant_id = req[1];
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: arbitrate, hold operands for the
// opcode latency, capture the result and return it on a tagged response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,

    output logic [OP_W-1:0]  alu_control,
    output logic [WIDTH-1:0] alu_oper1,
    output logic [WIDTH-1:0] alu_oper2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,

    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;

    logic             arb_en_c;
    logic             grant_valid;
    logic             grant_id;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [CNT_W-1:0] lat_m1;

    // Readys depend on the valids in the same cycle and are forced low under reset.
    assign arb_en_c = (state == IDLE) && rst_n;

    rr_arb2 u_rr_arb2 (
        .req         ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .en          (arb_en_c),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid &&  grant_id;

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;
    assign lat_m1 = is_mul(sel_op) ? CNT_W'(MUL_LAT - 1) : '0;

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_valid)     state_nxt = EXEC;
            EXEC: if (cnt == '0)       state_nxt = RESP;
            RESP: if (rsp_ready)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Operand drive, latency counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control  <= '0;
            alu_oper1    <= '0;
            alu_oper2    <= '0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            cnt          <= '0;
            last_grant   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_control <= sel_op;
                        alu_oper1   <= sel_a;
                        alu_oper2   <= sel_b;
                        rsp_id      <= grant_id;
                        last_grant  <= grant_id;
                        cnt         <= lat_m1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result   <= alu_result;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= (alu_result == '0);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
